// File: rtl/switches_scanner_if.sv
// Key-matrix scanner bus: board column readback and frame sync in,
// row drive and frame-stable key state out.
interface switches_scanner_if;
  logic [7:0] col_in;
  logic       vsync;
  logic [1:0] row_sel;
  logic [7:0] switches_p1;
  logic [7:0] switches_p2;
  logic [7:0] press_p1;
  logic [7:0] press_p2;
  logic       scan_done;

  // Board/game side.
  modport master (
    output col_in, vsync,
    input  row_sel, switches_p1, switches_p2, press_p1, press_p2, scan_done
  );

  // Scanner side.
  modport slave (
    input  col_in, vsync,
    output row_sel, switches_p1, switches_p2, press_p1, press_p2, scan_done
  );
endinterface

// File: rtl/switches_scanner.sv
// Two-row key-matrix scanner: shares the column lines between the two player
// rows, debounces every key and latches frame-stable key state on vsync.
module switches_scanner #(
  parameter int SETTLE_CYC     = 16,
  parameter int DEB_SAMPLES    = 4,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  switches_scanner_if.slave  bus
);

  localparam int CW = $clog2(DEB_SAMPLES);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            row_q, row_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [1:0]      row_sel_q, row_sel_d;
  logic [7:0]      raw_q, raw_d;
  logic            upd_q, upd_d;
  logic            upd_row_q, upd_row_d;
  logic [7:0]      deb_q [2];
  logic [7:0]      deb_d [2];
  logic [CW-1:0]   cnt_q [2][8];
  logic [CW-1:0]   cnt_d [2][8];
  logic            vsync_prev_q;
  logic [7:0]      sw_p1_q, sw_p1_d, sw_p2_q, sw_p2_d;
  logic [7:0]      press_p1_q, press_p1_d, press_p2_q, press_p2_d;
  logic            scan_done_q, scan_done_d;
  logic            capture_s;
  logic            vsync_rise_s;
  logic [7:0]      col_norm_s;

  assign col_norm_s   = COL_ACTIVE_LOW ? ~bus.col_in : bus.col_in;
  assign vsync_rise_s = bus.vsync & ~vsync_prev_q;

  // Scan sequencer: blank gap, settle, then a single sampling cycle per row.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    settle_d  = settle_q;
    capture_s = 1'b0;
    case (state_q)
      ST_BLANK: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_SAMPLE: begin
        capture_s = 1'b1;
        row_d     = ~row_q;
        state_d   = ST_BLANK;
      end
      default: begin
        state_d  = ST_BLANK;
        row_d    = 1'b0;
        settle_d = '0;
      end
    endcase
    // Row drive is registered, so decode it from the state being entered.
    if (state_d == ST_BLANK) begin
      row_sel_d = 2'b00;
    end else begin
      row_sel_d = row_d ? 2'b10 : 2'b01;
    end
    raw_d       = capture_s ? col_norm_s : raw_q;
    upd_d       = capture_s;
    upd_row_d   = row_q;
    scan_done_d = capture_s & row_q;
  end

  // Debounce: applied the cycle after a row is sampled, to that row only.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (upd_q) begin
      for (int b = 0; b < 8; b++) begin
        if (raw_q[b] == deb_q[upd_row_q][b]) begin
          cnt_d[upd_row_q][b] = '0;
        end else if (cnt_q[upd_row_q][b] == CW'(DEB_SAMPLES - 1)) begin
          deb_d[upd_row_q][b] = raw_q[b];
          cnt_d[upd_row_q][b] = '0;
        end else begin
          cnt_d[upd_row_q][b] = cnt_q[upd_row_q][b] + CW'(1);
        end
      end
    end else begin
      deb_d = deb_q;
    end
  end

  // Frame latch: latch uses the registered debounce state, never its update.
  always_comb begin
    if (vsync_rise_s) begin
      sw_p1_d    = deb_q[0];
      sw_p2_d    = deb_q[1];
      press_p1_d = deb_q[0] & ~sw_p1_q;
      press_p2_d = deb_q[1] & ~sw_p2_q;
    end else begin
      sw_p1_d    = sw_p1_q;
      sw_p2_d    = sw_p2_q;
      press_p1_d = 8'h00;
      press_p2_d = 8'h00;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      row_q        <= 1'b0;
      settle_q     <= '0;
      row_sel_q    <= 2'b00;
      raw_q        <= 8'h00;
      upd_q        <= 1'b0;
      upd_row_q    <= 1'b0;
      deb_q        <= '{default: '0};
      cnt_q        <= '{default: '0};
      vsync_prev_q <= 1'b1;
      sw_p1_q      <= 8'h00;
      sw_p2_q      <= 8'h00;
      press_p1_q   <= 8'h00;
      press_p2_q   <= 8'h00;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      row_sel_q    <= row_sel_d;
      raw_q        <= raw_d;
      upd_q        <= upd_d;
      upd_row_q    <= upd_row_d;
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      vsync_prev_q <= bus.vsync;
      sw_p1_q      <= sw_p1_d;
      sw_p2_q      <= sw_p2_d;
      press_p1_q   <= press_p1_d;
      press_p2_q   <= press_p2_d;
      scan_done_q  <= scan_done_d;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.switches_p1 = sw_p1_q;
  assign bus.switches_p2 = sw_p2_q;
  assign bus.press_p1    = press_p1_q;
  assign bus.press_p2    = press_p2_q;
  assign bus.scan_done   = scan_done_q;

endmodule

// File: tb/tb_switches_scanner.sv
// Bench for switches_scanner: a key-matrix model drives col_in, and a
// cycle-schedule reference model predicts every output on every cycle.
module tb_switches_scanner;
  localparam int SETTLE = 16;
  localparam int DEB    = 4;
  localparam int SLOT   = SETTLE + 2;
  localparam int SCAN   = 2 * SLOT;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keys_p1 = 8'h00;
  logic [7:0] keys_p2 = 8'h00;

  switches_scanner_if bus ();

  switches_scanner #(
    .SETTLE_CYC    (SETTLE),
    .DEB_SAMPLES   (DEB),
    .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pull-up matrix: a pressed key on the driven row pulls its column low.
  assign bus.col_in = ~(({8{bus.row_sel[0]}} & keys_p1) | ({8{bus.row_sel[1]}} & keys_p2));

  int checks = 0;
  int errors = 0;

  // Reference model state; k is the index of the current cycle since reset release.
  int         k;
  logic [7:0] m_deb [2];
  int         m_run [2][8];
  logic       m_pend;
  int         m_pend_row;
  logic [7:0] m_pend_val;
  logic [7:0] m_sw [2];
  logic [7:0] m_press [2];
  logic       m_done;
  logic       m_prev_v;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t (cycle %0d)", name, act, exp, $time, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_pend = 1'b0;
    m_pend_row = 0;
    m_pend_val = 8'h00;
    m_done = 1'b0;
    m_prev_v = 1'b1;
    for (int r = 0; r < 2; r++) begin
      m_deb[r] = 8'h00;
      m_sw[r] = 8'h00;
      m_press[r] = 8'h00;
      for (int b = 0; b < 8; b++) m_run[r][b] = 0;
    end
  endtask

  function automatic logic [1:0] exp_row_sel(input int c);
    int pos = c % SLOT;
    int row = (c / SLOT) % 2;
    if (pos == 0) return 2'b00;
    return (row == 1) ? 2'b10 : 2'b01;
  endfunction

  initial model_reset();

  // Model step at each clock edge, then compare all outputs just after it.
  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      if (bus.vsync && !m_prev_v) begin
        for (int r = 0; r < 2; r++) begin
          m_press[r] = m_deb[r] & ~m_sw[r];
          m_sw[r] = m_deb[r];
        end
      end else begin
        m_press[0] = 8'h00;
        m_press[1] = 8'h00;
      end
      m_prev_v = bus.vsync;
      if (m_pend) begin
        // A bit flips once DEB consecutive samples disagree with it.
        for (int b = 0; b < 8; b++) begin
          if (m_pend_val[b] == m_deb[m_pend_row][b]) begin
            m_run[m_pend_row][b] = 0;
          end else begin
            m_run[m_pend_row][b] = m_run[m_pend_row][b] + 1;
            if (m_run[m_pend_row][b] == DEB) begin
              m_deb[m_pend_row][b] = m_pend_val[b];
              m_run[m_pend_row][b] = 0;
            end
          end
        end
        m_pend = 1'b0;
      end
      if (k % SLOT == SLOT - 1) begin
        m_pend_row = (k / SLOT) % 2;
        m_pend_val = (m_pend_row == 1) ? keys_p2 : keys_p1;
        m_pend = 1'b1;
      end
      m_done = (k % SCAN == SCAN - 1);
      k++;
      #1;
      if (!reset) begin
        chk("row_sel", {6'b0, bus.row_sel}, {6'b0, exp_row_sel(k)});
        chk("switches_p1", bus.switches_p1, m_sw[0]);
        chk("switches_p2", bus.switches_p2, m_sw[1]);
        chk("press_p1", bus.press_p1, m_press[0]);
        chk("press_p2", bus.press_p2, m_press[1]);
        chk("scan_done", {7'b0, bus.scan_done}, {7'b0, m_done});
      end
    end
  end

  task automatic wait_cycle(input int n);
    while (k < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_row_sel", {6'b0, bus.row_sel}, 8'h00);
    chk("rst_sw_p1", bus.switches_p1, 8'h00);
    chk("rst_sw_p2", bus.switches_p2, 8'h00);
    chk("rst_press", bus.press_p1 | bus.press_p2, 8'h00);
    chk("rst_scan_done", {7'b0, bus.scan_done}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle vsync pulse whose rising edge is seen at the end of cycle n.
  task automatic pulse_at(input int n, input logic [7:0] exp_sw1, input logic [7:0] exp_pr1);
    wait_cycle(n);
    bus.vsync = 1'b1;
    @(posedge clk);
    #2;
    chk("lit_sw_p1", bus.switches_p1, exp_sw1);
    chk("lit_press_p1", bus.press_p1, exp_pr1);
    @(negedge clk);
    bus.vsync = 1'b0;
    @(posedge clk);
    #2;
    chk("lit_press_p1_drop", bus.press_p1, 8'h00);
  endtask

  initial begin
    int vs_wait;
    // Idle matrix with vsync high across reset release.
    bus.vsync = 1'b1;
    do_reset();
    wait_cycle(10);
    bus.vsync = 1'b0;
    wait_cycle(17);
    chk("lit_row_sel_c17", {6'b0, bus.row_sel}, 8'h01);
    wait_cycle(18);
    chk("lit_row_sel_c18", {6'b0, bus.row_sel}, 8'h00);
    wait_cycle(19);
    chk("lit_row_sel_c19", {6'b0, bus.row_sel}, 8'h02);
    wait_cycle(36);
    chk("lit_scan_done_c36", {7'b0, bus.scan_done}, 8'h01);
    pulse_at(40, 8'h00, 8'h00);
    pulse_at(75, 8'h00, 8'h00);

    // P1 key0 held from reset; debounce lands in the same cycle as a vsync edge.
    keys_p1 = 8'h01;
    do_reset();
    pulse_at(100, 8'h00, 8'h00);
    pulse_at(126, 8'h00, 8'h00);
    pulse_at(140, 8'h01, 8'h01);
    pulse_at(170, 8'h01, 8'h00);
    chk("lit_sw_p2_idle", bus.switches_p2, 8'h00);

    // Bounce: key0 alternates every scan, never stable long enough.
    keys_p1 = 8'h00;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wait_cycle(SCAN * i + 5);
      keys_p1 = (i % 2 == 0) ? 8'h01 : 8'h00;
      if (i == 3) pulse_at(SCAN * i + 20, 8'h00, 8'h00);
    end
    wait_cycle(SCAN * 10 + 5);
    keys_p1 = 8'h00;
    pulse_at(SCAN * 12, 8'h00, 8'h00);

    // Three pressed scans, one released, then four pressed.
    keys_p1 = 8'h01;
    do_reset();
    wait_cycle(100);
    keys_p1 = 8'h00;
    wait_cycle(130);
    keys_p1 = 8'h01;
    pulse_at(150, 8'h00, 8'h00);
    pulse_at(250, 8'h00, 8'h00);
    pulse_at(280, 8'h01, 8'h01);

    // Random key activity and random frame timing.
    keys_p1 = 8'h00;
    do_reset();
    vs_wait = $urandom_range(30, 120);
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) keys_p1 = 8'($urandom);
      if ($urandom_range(0, 59) == 0) keys_p2 = 8'($urandom);
      if ($urandom_range(0, 399) == 0) keys_p1 = 8'h00;
      if (bus.vsync) begin
        bus.vsync = 1'b0;
      end else if (vs_wait == 0) begin
        bus.vsync = 1'b1;
        vs_wait = $urandom_range(30, 120);
      end else begin
        vs_wait--;
      end
    end
    bus.vsync = 1'b0;

    // Reset in the middle of row 1 settle with all P2 keys latched.
    keys_p1 = 8'h00;
    keys_p2 = 8'hFF;
    do_reset();
    pulse_at(200, 8'h00, 8'h00);
    chk("lit_sw_p2_ff", bus.switches_p2, 8'hFF);
    wait_cycle(SCAN * 6 + 25);
    chk("lit_row_sel_mid_settle", {6'b0, bus.row_sel}, 8'h02);
    do_reset();
    wait_cycle(SETTLE);
    chk("lit_row_sel_settle_end", {6'b0, bus.row_sel}, 8'h01);
    wait_cycle(SETTLE + 1);
    chk("lit_row_sel_first_sample", {6'b0, bus.row_sel}, 8'h01);
    wait_cycle(SETTLE + 2);
    chk("lit_row_sel_after_sample", {6'b0, bus.row_sel}, 8'h00);
    chk("lit_sw_p2_cleared", bus.switches_p2, 8'h00);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
